// File: rtl/tt_mask_idx_seq_if.sv
// tt_mask_idx_seq_if: memop control, index-beat stream and LSU item/credit
// channel of the mask/index sequencer, bundled for port grouping.
interface tt_mask_idx_seq_if #(
    parameter int VLEN = 256
);
    localparam int VLW = $clog2(VLEN + 1);

    logic            i_start;
    logic            i_is_masked;
    logic            i_is_indexed;
    logic [VLW-1:0]  i_vl;
    logic [1:0]      i_eew;
    logic [VLEN-1:0] i_mask_data;
    logic [VLEN-1:0] i_index_data;
    logic            i_index_valid;
    logic            o_index_ready;
    logic            i_end;
    logic            i_kill;
    logic            i_credit;
    logic [64:0]     o_item;
    logic            o_valid;
    logic            o_last;

    modport master (
        output i_start, i_is_masked, i_is_indexed, i_vl, i_eew, i_mask_data,
               i_index_data, i_index_valid, i_end, i_kill, i_credit,
        input  o_index_ready, o_item, o_valid, o_last
    );

    modport slave (
        input  i_start, i_is_masked, i_is_indexed, i_vl, i_eew, i_mask_data,
               i_index_data, i_index_valid, i_end, i_kill, i_credit,
        output o_index_ready, o_item, o_valid, o_last
    );
endinterface

// File: rtl/tt_mask_idx_seq.sv
// tt_mask_idx_seq: streams mask words (masked unit-stride/strided) or one
// {mask bit, index} item per element (indexed) to the LSU under credit flow
// control. Index beats queue in a ring FIFO and drain as soon as one lands.
// Optional macro TT_MASK_IDX_SIGNEXT_EN: sign-extend indices from EEW to 64b
// (default zero-extends, i.e. unsigned offsets).
module tt_mask_idx_seq #(
    parameter int VLEN         = 256,
    parameter int MASK_CREDITS = 2,
    parameter int IDX_DEPTH    = 8
) (
    input logic              i_clk,
    input logic              i_reset_n,
    tt_mask_idx_seq_if.slave bus
);
    localparam int VLW = $clog2(VLEN + 1);
    localparam int LW  = $clog2(VLEN);
    localparam int PW  = $clog2(IDX_DEPTH);
    localparam int FCW = $clog2(IDX_DEPTH + 1);
    localparam int CW  = $clog2(MASK_CREDITS + 2);
`ifdef TT_MASK_IDX_SIGNEXT_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SEND, WAIT_END} state_t;
    state_t state, state_nxt;

    logic            mode_idx, mode_msk;
    logic [1:0]      eew_q;
    logic [VLEN-1:0] mask_q;
    logic [VLW-1:0]  remaining, pos;
    logic [LW-1:0]   elem_ptr, epb_m1;
    logic [VLEN-1:0] fifo_mem [IDX_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [FCW-1:0]  count, count_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic            start_ok, issue, push, pop, flush, last_elem;
    logic [VLEN-1:0] mask_clr, head;
    logic [VLW:0]    words;
    logic [63:0]     idx_ext, mask_word;
    logic [64:0]     item_c;

    // Issue qualification, FIFO bookkeeping and item formation
    always_comb begin
        mask_clr = '0;
        for (int i = 0; i < VLEN; i++)
            mask_clr[i] = bus.i_mask_data[i] && (i < int'(bus.i_vl));
        words     = ({1'b0, bus.i_vl} + (VLW+1)'(63)) >> 6;
        start_ok  = bus.i_start && (bus.i_is_masked || bus.i_is_indexed) && (bus.i_vl != '0);
        // o_valid is the item issued last cycle; a credit returned now is usable now
        cnt_nxt   = cnt + CW'(bus.i_credit) - CW'(bus.o_valid);
        issue     = (state == SEND) && !bus.i_kill && !bus.i_end && (remaining != '0) &&
                    (cnt_nxt != '0) && (!mode_idx || count != '0);
        epb_m1    = LW'((VLEN >> (3 + int'(eew_q))) - 1);
        // A partially used final beat is retired with the memop's last element
        last_elem = (elem_ptr == epb_m1) || (remaining == VLW'(1));
        pop       = issue && mode_idx && last_elem;
        push      = bus.i_index_valid && bus.o_index_ready && !bus.i_kill;
        flush     = bus.i_kill || ((state == SEND) && bus.i_end);
        count_nxt = flush ? FCW'(push) : count + FCW'(push) - FCW'(pop);
        head      = fifo_mem[rd_ptr];

        idx_ext = '0;
        for (int e = 0; e < VLEN/8; e++)
            if (eew_q == 2'd0 && elem_ptr == LW'(e))
                idx_ext = {{56{SEXT & head[e*8+7]}}, head[e*8 +: 8]};
        for (int e = 0; e < VLEN/16; e++)
            if (eew_q == 2'd1 && elem_ptr == LW'(e))
                idx_ext = {{48{SEXT & head[e*16+15]}}, head[e*16 +: 16]};
        for (int e = 0; e < VLEN/32; e++)
            if (eew_q == 2'd2 && elem_ptr == LW'(e))
                idx_ext = {{32{SEXT & head[e*32+31]}}, head[e*32 +: 32]};
        for (int e = 0; e < VLEN/64; e++)
            if (eew_q == 2'd3 && elem_ptr == LW'(e))
                idx_ext = head[e*64 +: 64];

        mask_word = '0;
        for (int w = 0; w < VLEN/64; w++)
            if (pos == VLW'(w)) mask_word = mask_q[w*64 +: 64];

        item_c = mode_idx ? {(mode_msk ? mask_q[pos[LW-1:0]] : 1'b1), idx_ext}
                          : {1'b0, mask_word};
    end

    // Next-state: kill dominates, early i_end aborts SEND
    always_comb begin
        state_nxt = state;
        if (bus.i_kill) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:     if (start_ok) state_nxt = SEND;
                SEND:     if (bus.i_end) state_nxt = IDLE;
                          else if (issue && remaining == VLW'(1)) state_nxt = WAIT_END;
                WAIT_END: if (bus.i_end) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Memop context: latched on start, advanced per issued item
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_idx  <= 1'b0;
            mode_msk  <= 1'b0;
            eew_q     <= '0;
            mask_q    <= '0;
            remaining <= '0;
            pos       <= '0;
            elem_ptr  <= '0;
        end else if (bus.i_kill || ((state == SEND) && bus.i_end)) begin
            remaining <= '0;
            pos       <= '0;
            elem_ptr  <= '0;
        end else if (state == IDLE && start_ok) begin
            mode_idx  <= bus.i_is_indexed;
            mode_msk  <= bus.i_is_masked;
            eew_q     <= bus.i_eew;
            mask_q    <= mask_clr;
            remaining <= bus.i_is_indexed ? bus.i_vl : VLW'(words);
            pos       <= '0;
            elem_ptr  <= '0;
        end else if (issue) begin
            remaining <= remaining - VLW'(1);
            pos       <= pos + VLW'(1);
            if (mode_idx) elem_ptr <= last_elem ? '0 : elem_ptr + LW'(1);
        end
    end

    // Index FIFO pointers; a flush keeps a same-cycle push as the new head
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            bus.o_index_ready <= 1'b1;
        end else begin
            if (flush) rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            count             <= count_nxt;
            bus.o_index_ready <= count_nxt < FCW'(IDX_DEPTH);
        end
    end

    // Index FIFO storage
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.i_index_data;
    end

    // LSU credit counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt <= CW'(MASK_CREDITS);
        else            cnt <= cnt_nxt;
    end

    // Registered item outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_valid <= 1'b0;
            bus.o_last  <= 1'b0;
            bus.o_item  <= '0;
        end else begin
            bus.o_valid <= issue;
            bus.o_last  <= issue && (remaining == VLW'(1));
            if (issue) bus.o_item <= item_c;
        end
    end

    a_start_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        bus.i_start |-> (state == IDLE));
    a_credit_ovf: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        cnt_nxt <= CW'(MASK_CREDITS));
endmodule

// File: tb/tb_tt_mask_idx_seq.sv
// tb_tt_mask_idx_seq: directed scenarios for the mask/index sequencer.
`timescale 1ns/1ps
module tb_tt_mask_idx_seq;
    localparam int VLEN  = 256;
    localparam int MC    = 2;
    localparam int DEPTH = 2;
    localparam int VLW   = $clog2(VLEN + 1);

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;

    tt_mask_idx_seq_if #(.VLEN(VLEN)) bus ();

    tt_mask_idx_seq #(.VLEN(VLEN), .MASK_CREDITS(MC), .IDX_DEPTH(DEPTH)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    logic [64:0] q_item[$];
    bit          q_last[$];
    int pending = 0, credit_delay = 0, ctimer = 0, max_out = 0;

    // LSU model: collects items and returns one credit per item after credit_delay cycles
    always @(negedge i_clk) begin
        if (bus.o_valid === 1'b1) begin
            q_item.push_back(bus.o_item);
            q_last.push_back(bus.o_last);
            pending++;
        end
        if (pending > max_out) max_out = pending;
        if (pending > 0 && ctimer >= credit_delay) begin
            bus.i_credit = 1'b1; pending--; ctimer = 0;
        end else begin
            bus.i_credit = 1'b0;
            if (pending > 0) ctimer++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [63:0] ext8(input logic [7:0] b);
`ifdef TT_MASK_IDX_SIGNEXT_EN
        return {{56{b[7]}}, b};
`else
        return {56'd0, b};
`endif
    endfunction

    task automatic step();
        @(negedge i_clk); #1;
    endtask

    task automatic start_memop(input bit m, input bit x, input int vl,
                               input logic [1:0] eew, input logic [VLEN-1:0] mask);
        bus.i_start = 1'b1; bus.i_is_masked = m; bus.i_is_indexed = x;
        bus.i_vl = VLW'(vl); bus.i_eew = eew; bus.i_mask_data = mask;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic push_beat(input logic [VLEN-1:0] d, output bit saw_full);
        int k = 0;
        saw_full = 1'b0;
        bus.i_index_valid = 1'b1; bus.i_index_data = d;
        while (bus.o_index_ready !== 1'b1 && k < 1000) begin saw_full = 1'b1; step(); k++; end
        if (k >= 1000) begin
            checks++; errors++;
            $display("FAIL push_timeout: o_index_ready=%b, required 1 within 1000 cycles", bus.o_index_ready);
        end
        step();
    endtask

    task automatic wait_items(input int n, input int bound);
        int k = 0;
        while (q_item.size() < n && k < bound) begin step(); k++; end
        if (k >= bound) begin
            checks++; errors++;
            $display("FAIL item_timeout: got %0d items, required %0d", q_item.size(), n);
        end
    endtask

    task automatic end_memop(input string nm);
        int k = 0;
        while (int'(dut.state) != 2 && k < 500) begin step(); k++; end
        checks++;
        if (k >= 500) begin errors++; $display("FAIL %s_wait_end: state=%0d, required 2", nm, int'(dut.state)); end
        bus.i_end = 1'b1; step(); bus.i_end = 1'b0;
        checks++;
        if (int'(dut.state) != 0) begin errors++; $display("FAIL %s_idle: state=%0d, required 0", nm, int'(dut.state)); end
    endtask

    task automatic test_reset();
        bus.i_start = 0; bus.i_is_masked = 0; bus.i_is_indexed = 0; bus.i_vl = '0;
        bus.i_eew = '0; bus.i_mask_data = '0; bus.i_index_data = '0;
        bus.i_index_valid = 0; bus.i_end = 0; bus.i_kill = 0;
        i_reset_n = 1'b0;
        repeat (3) step();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", bus.o_valid); end
        checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b, required 0", bus.o_last); end
        checks++; if (bus.o_item !== 65'd0) begin errors++; $display("FAIL rst_item: got %h, required 0", bus.o_item); end
        checks++; if (bus.o_index_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", bus.o_index_ready); end
        i_reset_n = 1'b1;
        step();
    endtask

    task automatic test_masked_strided();
        logic [64:0] exp_i [3];
        exp_i[0] = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        exp_i[1] = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        exp_i[2] = {1'b0, 64'h3};
        credit_delay = 0; q_item.delete(); q_last.delete();
        start_memop(1, 0, 130, 2'd0, '1);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL ms_lat_early: o_valid=%b, required 0", bus.o_valid); end
        step();
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL ms_lat_first: o_valid=%b, required 1", bus.o_valid); end
        wait_items(3, 50);
        repeat (4) step();
        checks++; if (q_item.size() != 3) begin errors++; $display("FAIL ms_count: got %0d, required 3", q_item.size()); end
        for (int i = 0; i < 3 && i < q_item.size(); i++) begin
            checks++; if (q_item[i] !== exp_i[i]) begin errors++; $display("FAIL ms_item%0d: got %h, required %h", i, q_item[i], exp_i[i]); end
            checks++; if (q_last[i] !== (i == 2)) begin errors++; $display("FAIL ms_last%0d: got %b, required %b", i, q_last[i], (i == 2)); end
        end
        end_memop("ms");
    endtask

    task automatic test_indexed_unmasked();
        logic [VLEN-1:0] beat;
        logic [64:0] e;
        bit full;
        beat = '0;
        beat[7:0] = 8'h80; beat[15:8] = 8'h01; beat[23:16] = 8'h02; beat[31:24] = 8'h03; beat[39:32] = 8'h04;
        q_item.delete(); q_last.delete();
        push_beat(beat, full);
        bus.i_index_valid = 1'b0;
        start_memop(0, 1, 5, 2'd0, '0);
        wait_items(5, 50);
        repeat (4) step();
        checks++; if (q_item.size() != 5) begin errors++; $display("FAIL iu_count: got %0d, required 5", q_item.size()); end
        for (int i = 0; i < 5 && i < q_item.size(); i++) begin
            e = (i == 0) ? {1'b1, ext8(8'h80)} : {1'b1, 64'(i)};
            checks++; if (q_item[i] !== e) begin errors++; $display("FAIL iu_item%0d: got %h, required %h", i, q_item[i], e); end
            checks++; if (q_last[i] !== (i == 4)) begin errors++; $display("FAIL iu_last%0d: got %b, required %b", i, q_last[i], (i == 4)); end
        end
        end_memop("iu");
        bus.i_kill = 1'b1; step(); bus.i_kill = 1'b0;
    endtask

    task automatic test_credits();
        logic [VLEN-1:0] b0, b1;
        logic [64:0] e;
        bit full;
        bit mb [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            b0[k*64 +: 64] = 64'hF000_0000_0000_0000 + 64'(k);
            b1[k*64 +: 64] = 64'hF000_0000_0000_0000 + 64'(k + 4);
        end
        credit_delay = 4; max_out = 0; q_item.delete(); q_last.delete();
        push_beat(b0, full);
        push_beat(b1, full);
        bus.i_index_valid = 1'b0;
        start_memop(1, 1, 8, 2'd3, 256'hA5);
        wait_items(8, 300);
        checks++; if (q_item.size() != 8) begin errors++; $display("FAIL cr_count: got %0d, required 8", q_item.size()); end
        for (int i = 0; i < 8 && i < q_item.size(); i++) begin
            e = {mb[i], 64'hF000_0000_0000_0000 + 64'(i)};
            checks++; if (q_item[i] !== e) begin errors++; $display("FAIL cr_item%0d: got %h, required %h", i, q_item[i], e); end
        end
        checks++; if (q_last.size() == 8 && q_last[7] !== 1'b1) begin errors++; $display("FAIL cr_last: got %b, required 1", q_last[7]); end
        checks++; if (max_out != MC) begin errors++; $display("FAIL cr_outstanding: max %0d, required %0d", max_out, MC); end
        end_memop("cr");
        credit_delay = 0;
        repeat (8) step();
    endtask

    task automatic test_back_to_back();
        logic [VLEN-1:0] beat;
        logic [64:0] e;
        bit full, any_full;
        int bad, last_at;
        credit_delay = 0; any_full = 0; q_item.delete(); q_last.delete();
        start_memop(0, 1, VLEN, 2'd0, '0);
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 32; k++) beat[k*8 +: 8] = 8'(b*32 + k);
            push_beat(beat, full);
            any_full |= full;
            if (b == 1) begin
                checks++; if (bus.o_index_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b, required 0", bus.o_index_ready); end
            end
        end
        bus.i_index_valid = 1'b0;
        wait_items(VLEN, 2000);
        repeat (4) step();
        checks++; if (!any_full) begin errors++; $display("FAIL b2b_backpressure: saw_full=%b, required 1", any_full); end
        checks++; if (q_item.size() != VLEN) begin errors++; $display("FAIL b2b_count: got %0d, required %0d", q_item.size(), VLEN); end
        bad = 0; last_at = -1;
        for (int i = 0; i < q_item.size(); i++) begin
            e = {1'b1, ext8(8'(i))};
            if (q_item[i] !== e) bad++;
            if (q_last[i]) last_at = i;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_items: %0d wrong items, required 0", bad); end
        checks++; if (last_at != VLEN - 1) begin errors++; $display("FAIL b2b_last: at %0d, required %0d", last_at, VLEN - 1); end
        end_memop("b2b");
    endtask

    task automatic test_kill();
        logic [VLEN-1:0] b0, b1;
        bit full;
        int k = 0;
        for (int j = 0; j < 4; j++) begin
            b0[j*64 +: 64] = 64'h40 + 64'(j);
            b1[j*64 +: 64] = 64'h44 + 64'(j);
        end
        credit_delay = 0; q_item.delete(); q_last.delete();
        push_beat(b0, full);
        push_beat(b1, full);
        bus.i_index_valid = 1'b0;
        start_memop(0, 1, 8, 2'd3, '0);
        while (q_item.size() < 3 && k < 100) begin step(); k++; end
        bus.i_kill = 1'b1; step(); bus.i_kill = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL kill_valid: got %b, required 0", bus.o_valid); end
        checks++; if (int'(dut.state) != 0) begin errors++; $display("FAIL kill_state: got %0d, required 0", int'(dut.state)); end
        checks++; if (int'(dut.count) != 0) begin errors++; $display("FAIL kill_fifo: count %0d, required 0", int'(dut.count)); end
        repeat (5) step();
        checks++; if (q_item.size() != 3) begin errors++; $display("FAIL kill_items: got %0d, required 3", q_item.size()); end
        q_item.delete(); q_last.delete();
        start_memop(1, 0, 1, 2'd0, '1);
        wait_items(1, 50);
        repeat (4) step();
        checks++; if (q_item.size() != 1) begin errors++; $display("FAIL kill_next_count: got %0d, required 1", q_item.size()); end
        if (q_item.size() >= 1) begin
            checks++; if (q_item[0] !== {1'b0, 64'h1}) begin errors++; $display("FAIL kill_next_item: got %h, required %h", q_item[0], {1'b0, 64'h1}); end
            checks++; if (q_last[0] !== 1'b1) begin errors++; $display("FAIL kill_next_last: got %b, required 1", q_last[0]); end
        end
        end_memop("kn");
    endtask

    task automatic test_zero_vl();
        q_item.delete(); q_last.delete();
        start_memop(1, 0, 0, 2'd0, '1);
        repeat (6) step();
        checks++; if (q_item.size() != 0) begin errors++; $display("FAIL zvl_items: got %0d, required 0", q_item.size()); end
        checks++; if (int'(dut.state) != 0) begin errors++; $display("FAIL zvl_state: got %0d, required 0", int'(dut.state)); end
        start_memop(0, 0, 5, 2'd0, '1);
        repeat (6) step();
        checks++; if (q_item.size() != 0) begin errors++; $display("FAIL nomode_items: got %0d, required 0", q_item.size()); end
        checks++; if (int'(dut.state) != 0) begin errors++; $display("FAIL nomode_state: got %0d, required 0", int'(dut.state)); end
    endtask

    initial begin
        test_reset();
        test_masked_strided();
        test_indexed_unmasked();
        test_credits();
        test_back_to_back();
        test_kill();
        test_zero_vl();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tt_mask_idx_seq.md
# tt_mask_idx_seq

Parametrised mask/index sequencer for the VPU load/store path. On each vector memop it streams either mask words (masked unit-stride/strided) or one {mask bit, index} item per element (indexed) to the LSU over a credit-based interface. Index register beats are buffered in a ring FIFO with backpressure and drained as soon as the first beat lands. It supports all EEWs with vl up to VLEN and an abort path.

## Interface
- VLEN, 256, vector register width in bits; multiple of 64
- MASK_CREDITS, 2, LSU-side item buffer depth (initial credit count)
- IDX_DEPTH, 8, index FIFO depth in VLEN-bit beats; power of two, ≥2
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  memop sync start pulse; qualifies mode/vl/eew/mask
- i_is_masked  in  1  memop is masked (vm=0)
- i_is_indexed  in  1  memop is indexed
- i_vl  in  $clog2(VLEN+1)  element count
- i_eew  in  2  index EEW: 0=8b, 1=16b, 2=32b, 3=64b
- i_mask_data  in  VLEN  v0 contents, sampled on i_start
- i_index_data  in  VLEN  index register beat
- i_index_valid  in  1  beat valid
- o_index_ready  out  1  FIFO can accept a beat
- i_end  in  1  memop sync end pulse
- i_kill  in  1  abort current memop
- i_credit  in  1  one credit returned by LSU
- o_item  out  65  [64]=element mask bit, [63:0]=index or mask word
- o_valid  out  1  o_item valid (one cycle per item)
- o_last  out  1  qualifies final item of the memop

## Operation
- States: IDLE, SEND, WAIT_END. Reset → IDLE.
- IDLE→SEND: i_start && (i_is_masked || i_is_indexed) && i_vl!=0. Latch mode, eew, mask_data (bits ≥ vl cleared), remaining := indexed ? vl : ceil(vl/64).
- i_start with vl==0 or neither mode: stay IDLE, emit nothing. i_start outside IDLE: ignored (SVA error).
- SEND→WAIT_END when the last item issues; WAIT_END→IDLE on i_end. i_end in SEND (protocol violation) → IDLE, FIFO flushed.
- i_kill (any state, highest priority) → IDLE next cycle; FIFO, pointers, remaining cleared; o_valid forced 0 next cycle; credit counter untouched.
- Non-indexed item: [63:0] = next 64 mask bits (LSB first), [64]=0.
- Indexed item: [64] = masked ? mask bit of element : 1; [63:0] = index extended to 64b (see Configuration). Element order: beat order, LSB first within beat; elems/beat = VLEN>>(3+eew).
- Index FIFO: push when i_index_valid && o_index_ready (accepted in any state except during i_kill); o_index_ready = count<IDX_DEPTH. Head beat popped when its last element issues; push and pop same cycle keep count. Beats arriving in IDLE are held for the next memop.
- Credits: cnt_next = cnt + i_credit − o_valid; reset MASK_CREDITS; cnt_next > MASK_CREDITS is an SVA error.
- Issue in cycle t when state==SEND, remaining>0, cnt_next>0, and (non-indexed || FIFO non-empty).

## Timing
- All outputs registered; reset values: o_item=0, o_valid=0, o_last=0, o_index_ready=1.
- Issue decision in t → o_valid/o_item/o_last in t+1. First item earliest 2 cycles after i_start (indexed: also ≥1 cycle after first beat accepted).
- Throughput 1 item/cycle while credits and indices available; credit returned in t usable in t.
- o_last asserted with the item that makes remaining 0.
- i_kill in t: no item issued from t onward; o_valid=0 at t+1.

## Configuration
- TT_MASK_IDX_SIGNEXT_EN defined: indices sign-extended from EEW to 64b.
- Undefined (default): indices zero-extended (RVV unsigned offsets). Mask-word path unaffected.

## Test plan
- Masked strided, vl=130, mask=all-ones → 3 items: 0xFFFF_FFFF_FFFF_FFFF ×2, then 0x3; o_last on 3rd; [64]=0.
- Indexed unmasked, eew=0, vl=5, beat bytes 0x80,01,02,03,04 → 5 items, [64]=1, first index 0x80 zero-ext (0xFFFF_FFFF_FFFF_FF80 with macro); o_last on 5th.
- Indexed masked, eew=3, vl=8 (2 beats), mask=0xA5, MASK_CREDITS=2, credits returned every 4 cycles → exactly 2 items outstanding max, [64] sequence 1,0,1,0,0,1,0,1.
- Indexed eew=0, vl=VLEN, IDX_DEPTH=2, beats offered back-to-back → o_index_ready drops with 2 beats queued, no beat lost, VLEN items in order.
- i_kill after 3 of 8 items → o_valid low next cycle, FIFO empty, state IDLE; following memop vl=1 emits one item with o_last.
- i_start with vl=0, masked → no o_valid; state stays IDLE.
